// File: rtl/lfsr_stream_if.sv
// rtl/lfsr_stream_if.sv - valid/ready word stream carrying LFSR output
interface lfsr_stream_if #(
  parameter int NBITS = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/lfsr_stream.sv
// rtl/lfsr_stream.sv - Galois LFSR word source with seed load, zero-lock recovery,
// transfer counter and period-complete pulse
module lfsr_stream #(
  parameter int               NBITS = 16,
  parameter logic [NBITS-1:0] TAPS  = NBITS'(16'h002D),
  parameter int               STEP  = 1,
  parameter logic [NBITS-1:0] SEED  = {NBITS{1'b1}},
  parameter int               CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [NBITS-1:0]   seed_in,
  lfsr_stream_if.master      out,
  output logic [CNT_W-1:0]   word_count,
  output logic               period_done,
  output logic               lock_err
);

  logic [NBITS-1:0] state_q;
  logic [NBITS-1:0] seed_q;
  logic             run_q;
  logic [NBITS-1:0] adv_state;
  logic             xfer;
  logic             seed_zero;
  logic             state_zero;

  function automatic logic [NBITS-1:0] lfsr_step(input logic [NBITS-1:0] s);
    lfsr_step = {s[NBITS-2:0], 1'b0} ^ (s[NBITS-1] ? TAPS : '0);
  endfunction

  // STEP shifts are unrolled so one accepted word advances the state STEP times
  always_comb begin
    adv_state = state_q;
    for (int i = 0; i < STEP; i++) begin
      adv_state = lfsr_step(adv_state);
    end
  end

  assign out.out_valid = run_q & ~load;
  assign out.out_data  = state_q;
  assign xfer          = out.out_valid & out.out_ready;
  assign seed_zero     = (seed_in == '0);
  assign state_zero    = (state_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEED;
      seed_q      <= SEED;
      run_q       <= 1'b0;
      word_count  <= '0;
      period_done <= 1'b0;
      lock_err    <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      period_done <= 1'b0;
      lock_err    <= 1'b0;
      if (load) begin
        word_count <= '0;
        if (seed_zero) begin
          state_q  <= SEED;
          seed_q   <= SEED;
          lock_err <= 1'b1;
        end else begin
          state_q <= seed_in;
          seed_q  <= seed_in;
        end
      end else if (xfer) begin
        // An all-zero state is a fixed point of the LFSR; restart from SEED
        if (state_zero) begin
          state_q    <= SEED;
          seed_q     <= SEED;
          lock_err   <= 1'b1;
          word_count <= '0;
        end else begin
          state_q     <= adv_state;
          word_count  <= word_count + CNT_W'(1);
          period_done <= (adv_state == seed_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream.sv
// tb/tb_lfsr_stream.sv - directed vector bench for lfsr_stream
module tb_lfsr_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_a, load_b, load_c;
  logic [15:0] seed_a, seed_b;
  logic [3:0]  seed_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic        pd_a, pd_b, pd_c;
  logic        le_a, le_b, le_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_stream_if #(.NBITS(16)) if_a ();
  lfsr_stream_if #(.NBITS(16)) if_b ();
  lfsr_stream_if #(.NBITS(4))  if_c ();

  lfsr_stream #(.NBITS(16), .TAPS(16'h001D), .STEP(1), .SEED(16'hFFFF), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .load(load_a), .seed_in(seed_a), .out(if_a.master),
    .word_count(cnt_a), .period_done(pd_a), .lock_err(le_a)
  );

  lfsr_stream #(.NBITS(16), .TAPS(16'h001D), .STEP(2), .SEED(16'hFFFF), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .load(load_b), .seed_in(seed_b), .out(if_b.master),
    .word_count(cnt_b), .period_done(pd_b), .lock_err(le_b)
  );

  lfsr_stream #(.NBITS(4), .TAPS(4'b0011), .STEP(1), .SEED(4'hF), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .load(load_c), .seed_in(seed_c), .out(if_c.master),
    .word_count(cnt_c), .period_done(pd_c), .lock_err(le_c)
  );

  typedef struct {
    logic        load;
    logic [15:0] seed;
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [15:0] exp_count;
    logic        exp_period;
    logic        exp_lock;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t        vecs[13];
    logic [3:0]  seq_c[15];

    vecs[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFE3, 16'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFDB, 16'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFE3, 16'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 16'h0001, 16'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 16'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 16'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 16'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 16'd0, 1'b0, 1'b0};

    seq_c = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
              4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

    reset = 1'b1;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    seed_a = '0;   seed_b = '0;   seed_c = '0;
    if_a.out_ready = 1'b0; if_b.out_ready = 1'b0; if_c.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_a", 32'(if_a.out_data), 32'hFFFF);
    chk("rst_valid_a", 32'(if_a.out_valid), 32'h0);
    chk("rst_count_a", 32'(cnt_a), 32'h0);
    chk("rst_pulses_a", 32'({pd_a, le_a}), 32'h0);
    chk("rst_data_c", 32'(if_c.out_data), 32'hF);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      load_a = vecs[i].load;
      seed_a = vecs[i].seed;
      if_a.out_ready = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(if_a.out_valid), 32'(vecs[i].exp_valid));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_data", i), 32'(if_a.out_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_count", i), 32'(cnt_a), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_period", i), 32'(pd_a), 32'(vecs[i].exp_period));
      chk($sformatf("vec%0d_lock", i), 32'(le_a), 32'(vecs[i].exp_lock));
      @(negedge clk);
    end
    load_a = 1'b0;
    if_a.out_ready = 1'b0;

    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_valid", 32'(if_a.out_valid), 32'h1);
      @(posedge clk);
      #1;
      chk("stall_data", 32'(if_a.out_data), 32'hFFFF);
      chk("stall_count", 32'(cnt_a), 32'h0);
      @(negedge clk);
    end
    if_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_stall_data", 32'(if_a.out_data), 32'hFFE3);
    chk("after_stall_count", 32'(cnt_a), 32'h1);
    @(negedge clk);
    if_a.out_ready = 1'b0;

    if_b.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("step2_data", 32'(if_b.out_data), 32'hFFDB);
    chk("step2_count", 32'(cnt_b), 32'h1);
    @(negedge clk);
    if_b.out_ready = 1'b0;

    force dut_a.state_q = 16'h0000;
    #1;
    release dut_a.state_q;
    chk("zero_forced_data", 32'(if_a.out_data), 32'h0);
    if_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("zero_lock_data", 32'(if_a.out_data), 32'hFFFF);
    chk("zero_lock_err", 32'(le_a), 32'h1);
    chk("zero_lock_count", 32'(cnt_a), 32'h0);
    @(negedge clk);
    if_a.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("zero_lock_clear", 32'(le_a), 32'h0);
    @(negedge clk);

    load_c = 1'b1;
    seed_c = 4'h1;
    if_c.out_ready = 1'b1;
    #1;
    chk("c_load_valid", 32'(if_c.out_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("c_load_data", 32'(if_c.out_data), 32'h1);
    chk("c_load_count", 32'(cnt_c), 32'h0);
    @(negedge clk);
    load_c = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("c_seq%0d_data", i), 32'(if_c.out_data), 32'(seq_c[i]));
      chk($sformatf("c_seq%0d_count", i), 32'(cnt_c), 32'(i + 1));
      chk($sformatf("c_seq%0d_period", i), 32'(pd_c), (i == 14) ? 32'h1 : 32'h0);
    end
    @(posedge clk);
    #1;
    chk("c_wrap_data", 32'(if_c.out_data), 32'h2);
    chk("c_wrap_count", 32'(cnt_c), 32'h0);
    chk("c_period_clear", 32'(pd_c), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    load_a = 1'b1;
    seed_a = 16'h1234;
    if_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_data_a", 32'(if_a.out_data), 32'hFFFF);
    chk("midrst_data_c", 32'(if_c.out_data), 32'hF);
    chk("midrst_count_c", 32'(cnt_c), 32'h0);
    chk("midrst_valid_c", 32'(if_c.out_valid), 32'h0);
    chk("midrst_pulses_c", 32'({pd_c, le_c}), 32'h0);
    chk("midrst_count_a", 32'(cnt_a), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
